// File: rtl/raster_dcr_writer.sv
// -----------------------------------------------------------------------------
// raster_dcr_writer
//
// Takes one raster configuration request over a valid/ready handshake and
// serialises it into six DCR bus writes (tile buffer address, tile count,
// primitive buffer address, primitive buffer stride, scissor X, scissor Y).
// The writes go to the raster unit's DCR slave. The DCR bus has no
// backpressure, so every cycle with dcr_write_valid=1 is a completed write.
//
// Optional feature (compile-time macro RASTER_DCR_SKIP_UNCHANGED_EN):
//   Keeps a shadow copy of each of the six data words. After the first
//   completed sequence, any index whose data matches its shadow is skipped.
//   A skipped index produces no write and no gap. Without the macro, all six
//   writes are always issued and no shadow state exists.
//
// Ports:
//   clk                 clock
//   reset               asynchronous, active-low reset. Release is assumed to
//                       be synchronised to clk upstream.
//   req_valid/ready     request handshake; ready only in IDLE
//   req_*               request fields, latched on acceptance
//   dcr_write_valid     one-cycle strobe per DCR write
//   dcr_write_addr      DCR address; holds its value between writes
//   dcr_write_data      DCR data; holds its value between writes
//   busy                high from the cycle after acceptance through done
//   done                one-cycle pulse when the sequence completes
// -----------------------------------------------------------------------------
module raster_dcr_writer #(
   parameter int unsigned ADDR_BITS         = 32,
   parameter int unsigned TILE_BITS         = 16,
   parameter int unsigned STRIDE_BITS       = 16,
   parameter int unsigned DIM_BITS          = 15,
   parameter int unsigned WRITE_GAP         = 0,
   parameter int unsigned VX_DCR_ADDR_WIDTH = 12,
   parameter int unsigned RASTER_DCR_BASE   = 'h010
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   output logic                         req_ready,
   input  logic [ADDR_BITS-1:0]         req_tbuf_addr,
   input  logic [TILE_BITS-1:0]         req_tile_count,
   input  logic [ADDR_BITS-1:0]         req_pbuf_addr,
   input  logic [STRIDE_BITS-1:0]       req_pbuf_stride,
   input  logic [DIM_BITS-1:0]          req_dst_xmin,
   input  logic [DIM_BITS-1:0]          req_dst_xmax,
   input  logic [DIM_BITS-1:0]          req_dst_ymin,
   input  logic [DIM_BITS-1:0]          req_dst_ymax,
   output logic                         dcr_write_valid,
   output logic [VX_DCR_ADDR_WIDTH-1:0] dcr_write_addr,
   output logic [31:0]                  dcr_write_data,
   output logic                         busy,
   output logic                         done
);

   localparam int unsigned VX_DCR_RASTER_TBUF_ADDR   = RASTER_DCR_BASE + 0;
   localparam int unsigned VX_DCR_RASTER_TILE_COUNT  = RASTER_DCR_BASE + 1;
   localparam int unsigned VX_DCR_RASTER_PBUF_ADDR   = RASTER_DCR_BASE + 2;
   localparam int unsigned VX_DCR_RASTER_PBUF_STRIDE = RASTER_DCR_BASE + 3;
   localparam int unsigned VX_DCR_RASTER_SCISSOR_X   = RASTER_DCR_BASE + 4;
   localparam int unsigned VX_DCR_RASTER_SCISSOR_Y   = RASTER_DCR_BASE + 5;

   typedef enum logic [1:0] {StIdle, StWrite, StGap, StFinish} state_e;

   state_e state_q, state_d;
   logic [2:0] idx_q, idx_d;
   logic [2:0] gap_q, gap_d;

   // Latched request fields
   logic [ADDR_BITS-1:0]   tbuf_q, tbuf_d;
   logic [TILE_BITS-1:0]   tiles_q, tiles_d;
   logic [ADDR_BITS-1:0]   pbuf_q, pbuf_d;
   logic [STRIDE_BITS-1:0] stride_q, stride_d;
   logic [DIM_BITS-1:0]    xmin_q, xmin_d, xmax_q, xmax_d;
   logic [DIM_BITS-1:0]    ymin_q, ymin_d, ymax_q, ymax_d;

   // Registered outputs
   logic                         wr_valid_q, wr_valid_d;
   logic [VX_DCR_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [31:0]                  wr_data_q, wr_data_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;

   logic        accept;
   logic [31:0] word [6];
   logic [5:0]  skip;
   logic [3:0]  search_from;
   logic        next_found;
   logic [2:0]  next_idx;

   assign req_ready = (state_q == StIdle) && reset;
   assign accept    = req_valid && req_ready;

   // Fields as seen this cycle: the fresh request on acceptance, else the latch.
   always_comb begin
      tbuf_d   = accept ? req_tbuf_addr   : tbuf_q;
      tiles_d  = accept ? req_tile_count  : tiles_q;
      pbuf_d   = accept ? req_pbuf_addr   : pbuf_q;
      stride_d = accept ? req_pbuf_stride : stride_q;
      xmin_d   = accept ? req_dst_xmin    : xmin_q;
      xmax_d   = accept ? req_dst_xmax    : xmax_q;
      ymin_d   = accept ? req_dst_ymin    : ymin_q;
      ymax_d   = accept ? req_dst_ymax    : ymax_q;
   end

   always_comb begin
      word[0] = 32'(tbuf_d);
      word[1] = 32'(tiles_d);
      word[2] = 32'(pbuf_d);
      word[3] = 32'(stride_d);
      word[4] = 32'(xmin_d) | (32'(xmax_d) << 16);
      word[5] = 32'(ymin_d) | (32'(ymax_d) << 16);
   end

`ifdef RASTER_DCR_SKIP_UNCHANGED_EN
   logic [31:0] shadow_q [6];
   logic        shadow_valid_q;

   always_comb begin
      skip = '0;
      for (int i = 0; i < 6; i++) begin
         skip[i] = shadow_valid_q && (word[i] == shadow_q[i]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shadow_valid_q <= 1'b0;
         for (int i = 0; i < 6; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < 6; i++) begin
            if (wr_valid_d && (idx_d == 3'(i))) begin
               shadow_q[i] <= wr_data_d;
            end
         end
         if (state_q == StFinish) begin
            shadow_valid_q <= 1'b1;
         end
      end
   end
`else
   assign skip = '0;
`endif

   // Lowest non-skipped index at or after search_from.
   always_comb begin
      search_from = (state_q == StIdle) ? 4'd0 : ({1'b0, idx_q} + 4'd1);
      next_found  = 1'b0;
      next_idx    = '0;
      for (int i = 5; i >= 0; i--) begin
         if ((4'(i) >= search_from) && !skip[i]) begin
            next_found = 1'b1;
            next_idx   = 3'(i);
         end
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         idx_q   <= '0;
         gap_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         gap_q   <= gap_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      gap_d   = gap_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               if (next_found) begin
                  state_d = StWrite;
                  idx_d   = next_idx;
               end else begin
                  state_d = StFinish;
               end
            end
         end
         StWrite: begin
            if (!next_found) begin
               state_d = StFinish;
            end else if (WRITE_GAP == 0) begin
               state_d = StWrite;
               idx_d   = next_idx;
            end else begin
               // idx already points at the pending write while gapping
               state_d = StGap;
               idx_d   = next_idx;
               gap_d   = 3'(WRITE_GAP - 1);
            end
         end
         StGap: begin
            if (gap_q == '0) begin
               state_d = StWrite;
            end else begin
               gap_d = gap_q - 3'd1;
            end
         end
         StFinish: state_d = StIdle;
         default:  state_d = StIdle;
      endcase
   end

   // Output logic: next values of the registered outputs follow state_d.
   always_comb begin
      wr_valid_d = (state_d == StWrite);
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      busy_d     = (state_d != StIdle);
      done_d     = (state_d == StFinish);
      if (wr_valid_d) begin
         unique case (idx_d)
            3'd0: begin
               wr_addr_d = VX_DCR_ADDR_WIDTH'(VX_DCR_RASTER_TBUF_ADDR);
               wr_data_d = word[0];
            end
            3'd1: begin
               wr_addr_d = VX_DCR_ADDR_WIDTH'(VX_DCR_RASTER_TILE_COUNT);
               wr_data_d = word[1];
            end
            3'd2: begin
               wr_addr_d = VX_DCR_ADDR_WIDTH'(VX_DCR_RASTER_PBUF_ADDR);
               wr_data_d = word[2];
            end
            3'd3: begin
               wr_addr_d = VX_DCR_ADDR_WIDTH'(VX_DCR_RASTER_PBUF_STRIDE);
               wr_data_d = word[3];
            end
            3'd4: begin
               wr_addr_d = VX_DCR_ADDR_WIDTH'(VX_DCR_RASTER_SCISSOR_X);
               wr_data_d = word[4];
            end
            3'd5: begin
               wr_addr_d = VX_DCR_ADDR_WIDTH'(VX_DCR_RASTER_SCISSOR_Y);
               wr_data_d = word[5];
            end
            default: begin
               wr_addr_d = wr_addr_q;
               wr_data_d = wr_data_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         tbuf_q     <= '0;
         tiles_q    <= '0;
         pbuf_q     <= '0;
         stride_q   <= '0;
         xmin_q     <= '0;
         xmax_q     <= '0;
         ymin_q     <= '0;
         ymax_q     <= '0;
      end else begin
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         tbuf_q     <= tbuf_d;
         tiles_q    <= tiles_d;
         pbuf_q     <= pbuf_d;
         stride_q   <= stride_d;
         xmin_q     <= xmin_d;
         xmax_q     <= xmax_d;
         ymin_q     <= ymin_d;
         ymax_q     <= ymax_d;
      end
   end

   assign dcr_write_valid = wr_valid_q;
   assign dcr_write_addr  = wr_addr_q;
   assign dcr_write_data  = wr_data_q;
   assign busy            = busy_q;
   assign done            = done_q;

endmodule

// File: tb/tb_raster_dcr_writer.sv
// -----------------------------------------------------------------------------
// tb_raster_dcr_writer
//
// Two instances share one request bus: u_dut0 with WRITE_GAP=0 and u_dut1 with
// WRITE_GAP=2. A request-level model builds the expected cycle-by-cycle trace
// (write list, gaps, done, busy, ready, held addr/data) for each request.
// -----------------------------------------------------------------------------
module tb_raster_dcr_writer;

   localparam logic [11:0] Base = 12'h010;

   typedef struct packed {
      logic [31:0] tbuf;
      logic [15:0] tiles;
      logic [31:0] pbuf;
      logic [15:0] stride;
      logic [14:0] xmin;
      logic [14:0] xmax;
      logic [14:0] ymin;
      logic [14:0] ymax;
   } req_t;

   typedef struct packed {
      logic        wv;
      logic [11:0] a;
      logic [31:0] d;
      logic        busy;
      logic        done;
      logic        ready;
   } cyc_t;

   logic        clk;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  rdy, wv, busy, done;
   logic [11:0] wa [2];
   logic [31:0] wd [2];
   req_t        cur;

   int tests_run;
   int tests_failed;

   // Model state
   logic [11:0] last_a [2];
   logic [31:0] last_d [2];
   logic [31:0] msh [2][6];
   bit          mshv [2];
   req_t        prev [2];
   cyc_t        exp_tr [$];
   cyc_t        obs_tr [$];
   bit          issue_ok;

   raster_dcr_writer #(.WRITE_GAP(0)) u_dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid[0]), .req_ready(rdy[0]),
      .req_tbuf_addr(cur.tbuf), .req_tile_count(cur.tiles), .req_pbuf_addr(cur.pbuf),
      .req_pbuf_stride(cur.stride), .req_dst_xmin(cur.xmin), .req_dst_xmax(cur.xmax),
      .req_dst_ymin(cur.ymin), .req_dst_ymax(cur.ymax), .dcr_write_valid(wv[0]),
      .dcr_write_addr(wa[0]), .dcr_write_data(wd[0]), .busy(busy[0]), .done(done[0])
   );

   raster_dcr_writer #(.WRITE_GAP(2)) u_dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid[1]), .req_ready(rdy[1]),
      .req_tbuf_addr(cur.tbuf), .req_tile_count(cur.tiles), .req_pbuf_addr(cur.pbuf),
      .req_pbuf_stride(cur.stride), .req_dst_xmin(cur.xmin), .req_dst_xmax(cur.xmax),
      .req_dst_ymin(cur.ymin), .req_dst_ymax(cur.ymax), .dcr_write_valid(wv[1]),
      .dcr_write_addr(wa[1]), .dcr_write_data(wd[1]), .busy(busy[1]), .done(done[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, want finish before time 400000");
      $fatal(1);
   end

   function automatic cyc_t sample(input int w);
      cyc_t c;
      c.wv    = wv[w];
      c.a     = wa[w];
      c.d     = wd[w];
      c.busy  = busy[w];
      c.done  = done[w];
      c.ready = rdy[w];
      return c;
   endfunction

   function automatic string fmt(input cyc_t c);
      return $sformatf("wv=%b addr=%h data=%h busy=%b done=%b ready=%b",
                       c.wv, c.a, c.d, c.busy, c.done, c.ready);
   endfunction

   function automatic logic [31:0] word_of(input req_t r, input int i);
      case (i)
         0:       return r.tbuf;
         1:       return 32'(r.tiles);
         2:       return r.pbuf;
         3:       return 32'(r.stride);
         4:       return 32'(r.xmin) + 32'(r.xmax) * 32'h10000;
         default: return 32'(r.ymin) + 32'(r.ymax) * 32'h10000;
      endcase
   endfunction

   function automatic req_t rand_req();
      req_t r;
      r.tbuf   = $urandom;
      r.tiles  = 16'($urandom);
      r.pbuf   = $urandom;
      r.stride = 16'($urandom);
      r.xmin   = 15'($urandom);
      r.xmax   = 15'($urandom);
      r.ymin   = 15'($urandom);
      r.ymax   = 15'($urandom);
      return r;
   endfunction

   function automatic req_t plan_req();
      req_t r;
      r.tbuf   = 32'h1000;
      r.tiles  = 16'd4;
      r.pbuf   = 32'h2000;
      r.stride = 16'd64;
      r.xmin   = 15'd0;
      r.xmax   = 15'd639;
      r.ymin   = 15'd0;
      r.ymax   = 15'd479;
      return r;
   endfunction

   // Appends the expected cycles T+1 .. done for one request.
   task automatic model_seq(input int w, input req_t r);
      int          gap;
      int          issued [$];
      logic [31:0] wd_m [6];
      gap = (w == 0) ? 0 : 2;
      for (int i = 0; i < 6; i++) begin
         wd_m[i] = word_of(r, i);
`ifdef RASTER_DCR_SKIP_UNCHANGED_EN
         if (mshv[w] && (msh[w][i] == wd_m[i])) continue;
`endif
         issued.push_back(i);
      end
      foreach (issued[n]) begin
         if (n > 0) begin
            repeat (gap) exp_tr.push_back({1'b0, last_a[w], last_d[w], 1'b1, 1'b0, 1'b0});
         end
         last_a[w] = Base + 12'(issued[n]);
         last_d[w] = wd_m[issued[n]];
         msh[w][issued[n]] = wd_m[issued[n]];
         exp_tr.push_back({1'b1, last_a[w], last_d[w], 1'b1, 1'b0, 1'b0});
      end
      exp_tr.push_back({1'b0, last_a[w], last_d[w], 1'b1, 1'b1, 1'b0});
      mshv[w] = 1'b1;
   endtask

   task automatic model_idle(input int w);
      exp_tr.push_back({1'b0, last_a[w], last_d[w], 1'b0, 1'b0, 1'b1});
   endtask

   task automatic model_reset();
      for (int w = 0; w < 2; w++) begin
         last_a[w] = '0;
         last_d[w] = '0;
         mshv[w]   = 1'b0;
         for (int i = 0; i < 6; i++) msh[w][i] = '0;
      end
   endtask

   // Presents r and returns just after the accepting edge (cycle T).
   task automatic issue(input int w, input req_t r);
      cur          = r;
      req_valid[w] = 1'b1;
      issue_ok     = 1'b0;
      for (int i = 0; i < 40 && !issue_ok; i++) begin
         @(negedge clk);
         if (rdy[w] === 1'b1) issue_ok = 1'b1;
      end
      if (issue_ok) @(posedge clk);
      #1 req_valid[w] = 1'b0;
   endtask

   task automatic capture(input int w, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         obs_tr.push_back(sample(w));
      end
   endtask

   task automatic run_request(input int w, input req_t r);
      exp_tr.delete();
      obs_tr.delete();
      model_seq(w, r);
      model_idle(w);
      issue(w, r);
      capture(w, exp_tr.size());
      prev[w] = r;
   endtask

   task automatic test_reset();
      cyc_t c;
      reset     = 1'b0;
      req_valid = '0;
      cur       = '0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         c = sample(w);
         tests_run++;
         if (c !== '0) begin
            tests_failed++;
            $display("FAIL reset_hold dut%0d: got %s, want all zero", w, fmt(c));
         end
      end
      reset = 1'b1;
      @(negedge clk);
      for (int w = 0; w < 2; w++) begin
         c = sample(w);
         tests_run++;
         if (c !== {1'b0, 12'h0, 32'h0, 3'b001}) begin
            tests_failed++;
            $display("FAIL reset_release dut%0d: got %s, want idle with ready=1", w, fmt(c));
         end
      end
   endtask

   task automatic test_plan_request();
      int sx;
      int dn;
      for (int w = 0; w < 2; w++) begin
         run_request(w, plan_req());
         tests_run++;
         if (!issue_ok) begin
            tests_failed++;
            $display("FAIL plan_accept dut%0d: got ready never high, want accept", w);
         end
         for (int k = 0; k < exp_tr.size(); k++) begin
            tests_run++;
            if (obs_tr[k] !== exp_tr[k]) begin
               tests_failed++;
               $display("FAIL plan_dut%0d T+%0d: got %s, want %s", w, k + 1,
                        fmt(obs_tr[k]), fmt(exp_tr[k]));
            end
         end
         // Scissor X lands at T+5 without gaps, T+13 with two-cycle gaps.
         sx = (w == 0) ? 4 : 12;
         dn = (w == 0) ? 6 : 16;
         tests_run++;
         if ({obs_tr[sx].wv, obs_tr[sx].a, obs_tr[sx].d} !== {1'b1, Base + 12'd4, 32'h027F0000}) begin
            tests_failed++;
            $display("FAIL plan_scissor_x dut%0d: got wv=%b addr=%h data=%h, want 1 %h 027f0000",
                     w, obs_tr[sx].wv, obs_tr[sx].a, obs_tr[sx].d, Base + 12'd4);
         end
         tests_run++;
         if (obs_tr[dn].done !== 1'b1) begin
            tests_failed++;
            $display("FAIL plan_done dut%0d: got done=%b at T+%0d, want 1", w, obs_tr[dn].done,
                     dn + 1);
         end
      end
   endtask

   task automatic test_max_values();
      req_t        r;
      logic [31:0] got_x;
      logic [31:0] got_t;
      r = rand_req();
      r.tiles = 16'hFFFF;
      r.xmin  = 15'h0;
      r.xmax  = 15'h7FFF;
      r.ymin  = 15'h7FFF;
      r.ymax  = 15'h7FFF;
      run_request(0, r);
      for (int k = 0; k < exp_tr.size(); k++) begin
         tests_run++;
         if (obs_tr[k] !== exp_tr[k]) begin
            tests_failed++;
            $display("FAIL max_values T+%0d: got %s, want %s", k + 1, fmt(obs_tr[k]),
                     fmt(exp_tr[k]));
         end
      end
      got_x = 'x;
      got_t = 'x;
      foreach (obs_tr[k]) begin
         if (obs_tr[k].wv === 1'b1 && obs_tr[k].a == Base + 12'd4) got_x = obs_tr[k].d;
         if (obs_tr[k].wv === 1'b1 && obs_tr[k].a == Base + 12'd1) got_t = obs_tr[k].d;
      end
      tests_run++;
      if (got_x !== 32'h7FFF0000) begin
         tests_failed++;
         $display("FAIL max_scissor_x: got %h, want 7fff0000", got_x);
      end
      tests_run++;
      if (got_t !== 32'h0000FFFF) begin
         tests_failed++;
         $display("FAIL max_tile_count: got %h, want 0000ffff", got_t);
      end
   endtask

   task automatic test_back_to_back();
      req_t a;
      req_t b;
      int   len_a;
      int   k_acc;
      bit   sw;
      bit   ok;
      a = rand_req();
      b = rand_req();
      exp_tr.delete();
      obs_tr.delete();
      model_seq(0, a);
      len_a = exp_tr.size();
      model_idle(0);
      model_seq(0, b);
      model_idle(0);
      cur          = a;
      req_valid[0] = 1'b1;
      ok           = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (rdy[0] === 1'b1) ok = 1'b1;
      end
      @(posedge clk);
      #1 cur = b;
      sw    = 1'b0;
      k_acc = 0;
      for (int k = 1; k <= exp_tr.size(); k++) begin
         @(negedge clk);
         obs_tr.push_back(sample(0));
         if (rdy[0] === 1'b1 && !sw) begin
            sw    = 1'b1;
            k_acc = k;
            @(posedge clk);
            #1 req_valid[0] = 1'b0;
         end
      end
      req_valid[0] = 1'b0;
      prev[0]      = b;
      for (int k = 0; k < exp_tr.size(); k++) begin
         tests_run++;
         if (obs_tr[k] !== exp_tr[k]) begin
            tests_failed++;
            $display("FAIL back_to_back T+%0d: got %s, want %s", k + 1, fmt(obs_tr[k]),
                     fmt(exp_tr[k]));
         end
      end
      tests_run++;
      if (k_acc != len_a + 1) begin
         tests_failed++;
         $display("FAIL back_to_back_accept: got second accept at T+%0d, want T+%0d", k_acc,
                  len_a + 1);
      end
   endtask

   task automatic test_resend();
      req_t r;
      r = plan_req();
      for (int step = 0; step < 3; step++) begin
         if (step == 2) r.stride = 16'd128;
         run_request(0, r);
         for (int k = 0; k < exp_tr.size(); k++) begin
            tests_run++;
            if (obs_tr[k] !== exp_tr[k]) begin
               tests_failed++;
               $display("FAIL resend_step%0d T+%0d: got %s, want %s", step, k + 1,
                        fmt(obs_tr[k]), fmt(exp_tr[k]));
            end
         end
`ifdef RASTER_DCR_SKIP_UNCHANGED_EN
         if (step == 1) begin
            tests_run++;
            if ({obs_tr[0].wv, obs_tr[0].done} !== 2'b01) begin
               tests_failed++;
               $display("FAIL skip_identical: got wv=%b done=%b at T+1, want wv=0 done=1",
                        obs_tr[0].wv, obs_tr[0].done);
            end
         end
         if (step == 2) begin
            tests_run++;
            if ({obs_tr[0].wv, obs_tr[0].a, obs_tr[0].d, obs_tr[1].done}
                !== {1'b1, Base + 12'd3, 32'd128, 1'b1}) begin
               tests_failed++;
               $display("FAIL skip_stride_only: got wv=%b addr=%h data=%h done(T+2)=%b, %s",
                        obs_tr[0].wv, obs_tr[0].a, obs_tr[0].d, obs_tr[1].done,
                        "want one stride write of 128 then done");
            end
         end
`endif
      end
   endtask

   task automatic test_random();
      req_t r;
      int   w;
      for (int it = 0; it < 24; it++) begin
         w = it % 2;
         case ($urandom_range(0, 3))
            0: r = rand_req();
            1: r = prev[w];
            2: begin
               r = prev[w];
               case ($urandom_range(0, 7))
                  0: r.tbuf   = $urandom;
                  1: r.tiles  = 16'($urandom);
                  2: r.pbuf   = $urandom;
                  3: r.stride = 16'($urandom);
                  4: r.xmin   = 15'($urandom);
                  5: r.xmax   = 15'($urandom);
                  6: r.ymin   = 15'($urandom);
                  default: r.ymax = 15'($urandom);
               endcase
            end
            default: r = rand_req();
         endcase
         run_request(w, r);
         for (int k = 0; k < exp_tr.size(); k++) begin
            tests_run++;
            if (obs_tr[k] !== exp_tr[k]) begin
               tests_failed++;
               $display("FAIL random_%0d dut%0d T+%0d: got %s, want %s", it, w, k + 1,
                        fmt(obs_tr[k]), fmt(exp_tr[k]));
            end
         end
      end
   endtask

   task automatic test_reset_abort();
      req_t r;
      r = rand_req();
      exp_tr.delete();
      obs_tr.delete();
      model_seq(0, r);
      issue(0, r);
      capture(0, 2);
      for (int k = 0; k < 2; k++) begin
         tests_run++;
         if (obs_tr[k] !== exp_tr[k]) begin
            tests_failed++;
            $display("FAIL abort_prefix T+%0d: got %s, want %s", k + 1, fmt(obs_tr[k]),
                     fmt(exp_tr[k]));
         end
      end
      @(posedge clk);
      #2 reset = 1'b0;
      #1;
      for (int w = 0; w < 2; w++) begin
         tests_run++;
         if ({wv[w], busy[w], done[w], rdy[w]} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL abort_async dut%0d: got wv=%b busy=%b done=%b ready=%b, want 0000",
                     w, wv[w], busy[w], done[w], rdy[w]);
         end
      end
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      exp_tr.delete();
      obs_tr.delete();
      repeat (10) model_idle(0);
      capture(0, 10);
      for (int k = 0; k < exp_tr.size(); k++) begin
         tests_run++;
         if (obs_tr[k] !== exp_tr[k]) begin
            tests_failed++;
            $display("FAIL abort_after cycle %0d: got %s, want %s", k + 1, fmt(obs_tr[k]),
                     fmt(exp_tr[k]));
         end
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      test_reset();
      test_plan_request();
      test_max_values();
      test_back_to_back();
      test_resend();
      test_random();
      test_reset_abort();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
